llpktbuild: RTL and testbench

Synthesizable packet-builder stage that sits directly upstream of the link list manager's output-port queue. It consumes a per-page packet token stream, allocates one page per token from the free list, and writes forward links into link memory. At end-of-packet it terminates the chain with the stop page and enqueues the packet's start page onto the output queue (`op_*`), which the write port then walks and reclaims.

---
 rtl/llpktbuild_if.sv | 31 +++
 rtl/llpktbuild.sv | 123 ++++++++++++
 tb/tb_llpktbuild.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/llpktbuild_if.sv
// Handshake bundle for the packet builder: token input, free-list request/response,
// link-memory write and output-queue descriptor channels.
interface llpktbuild_if #(
  parameter int lpsz  = 8,
  parameter int lpdsz = lpsz + 1
);
  logic                    ip_srdy;
  logic                    ip_drdy;
  logic                    ip_eop;
  logic                    par_srdy;
  logic                    par_drdy;
  logic                    parr_srdy;
  logic                    parr_drdy;
  logic [lpsz-1:0]         parr_page;
  logic                    lnp_srdy;
  logic                    lnp_drdy;
  logic [lpsz+lpdsz-1:0]   lnp_pnp;
  logic                    op_srdy;
  logic                    op_drdy;
  logic [lpsz-1:0]         op_page;

  modport master (
    input  ip_srdy, ip_eop, par_drdy, parr_srdy, parr_page, lnp_drdy, op_drdy,
    output ip_drdy, par_srdy, parr_drdy, lnp_srdy, lnp_pnp, op_srdy, op_page
  );

  modport slave (
    output ip_srdy, ip_eop, par_drdy, parr_srdy, parr_page, lnp_drdy, op_drdy,
    input  ip_drdy, par_srdy, parr_drdy, lnp_srdy, lnp_pnp, op_srdy, op_page
  );
endinterface

// File: rtl/llpktbuild.sv
// Packet builder: allocates one page per token, chains pages in link memory,
// terminates the chain with the stop page and hands the start page to the output queue.
module llpktbuild #(
  parameter int lpsz  = 8,
  parameter int lpdsz = lpsz + 1,
  parameter int cntw  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  llpktbuild_if.master      bus,
  output logic [cntw-1:0]   pkt_count,
  output logic [cntw-1:0]   page_count
);

  localparam logic [lpdsz-1:0] STOP_PAGE = {1'b1, {(lpdsz-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    LINK,
    ACK,
    TAIL,
    EMIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [lpsz-1:0]   start;
  logic [lpsz-1:0]   prev;
  logic [lpsz-1:0]   newp;
  logic              have_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs depend only on the state register, never on peer inputs.
  always_comb begin
    state_nxt     = state;
    bus.ip_drdy   = 1'b0;
    bus.par_srdy  = 1'b0;
    bus.parr_drdy = 1'b0;
    bus.lnp_srdy  = 1'b0;
    bus.lnp_pnp   = '0;
    bus.op_srdy   = 1'b0;
    bus.op_page   = '0;
    case (state)
      IDLE: begin
        if (bus.ip_srdy) state_nxt = REQ;
      end
      REQ: begin
        bus.par_srdy = 1'b1;
        if (bus.par_drdy) state_nxt = RESP;
      end
      RESP: begin
        bus.parr_drdy = 1'b1;
        if (bus.parr_srdy) state_nxt = have_prev ? LINK : ACK;
      end
      LINK: begin
        bus.lnp_srdy = 1'b1;
        bus.lnp_pnp  = {prev, 1'b0, newp};
        if (bus.lnp_drdy) state_nxt = ACK;
      end
      ACK: begin
        bus.ip_drdy = 1'b1;
        state_nxt   = bus.ip_eop ? TAIL : IDLE;
      end
      TAIL: begin
        bus.lnp_srdy = 1'b1;
        bus.lnp_pnp  = {prev, STOP_PAGE};
        if (bus.lnp_drdy) state_nxt = EMIT;
      end
      EMIT: begin
        bus.op_srdy = 1'b1;
        bus.op_page = start;
        if (bus.op_drdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first page of a packet seeds both the chain head and the link source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start      <= '0;
      prev       <= '0;
      newp       <= '0;
      have_prev  <= 1'b0;
      pkt_count  <= '0;
      page_count <= '0;
    end else begin
      case (state)
        RESP: begin
          if (bus.parr_srdy) begin
            newp       <= bus.parr_page;
            page_count <= page_count + cntw'(1);
            if (!have_prev) begin
              start     <= bus.parr_page;
              prev      <= bus.parr_page;
              have_prev <= 1'b1;
            end
          end
        end
        LINK: begin
          if (bus.lnp_drdy) prev <= newp;
        end
        EMIT: begin
          if (bus.op_drdy) begin
            have_prev <= 1'b0;
            pkt_count <= pkt_count + cntw'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_llpktbuild.sv
// Bench for llpktbuild: a free-list/link/output-queue responder with optional stalls,
// and a packet-level model predicting link writes, descriptors and counters.
module tb_llpktbuild;

  localparam int LPSZ  = 8;
  localparam int LPDSZ = LPSZ + 1;
  localparam int CNTW  = 4;
  localparam logic [LPDSZ-1:0] STOP = 9'h100;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [CNTW-1:0]   pkt_count;
  logic [CNTW-1:0]   page_count;

  llpktbuild_if #(.lpsz(LPSZ), .lpdsz(LPDSZ)) bus ();

  llpktbuild #(.lpsz(LPSZ), .lpdsz(LPDSZ), .cntw(CNTW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .pkt_count  (pkt_count),
    .page_count (page_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [LPSZ-1:0]        pg_q[$];
  logic [LPSZ-1:0]        fl_q[$];
  logic [LPSZ+LPDSZ-1:0]  exp_lnp[$];
  logic [LPSZ-1:0]        exp_op[$];
  logic [CNTW-1:0]        exp_pkt = '0;
  logic [CNTW-1:0]        exp_page = '0;
  int  hold_par = 0, hold_parr = 0, hold_lnp = 0, hold_op = 0;
  bit  rnd_stall = 1'b0;
  bit  pv_par, pv_parr, pv_lnp, pv_op;
  int  ip_acks = 0;
  int  op_done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peer responder: drives every drdy/srdy the design waits on and checks its outputs.
  initial begin
    bus.par_drdy = 1'b0; bus.parr_srdy = 1'b0; bus.parr_page = '0;
    bus.lnp_drdy = 1'b0; bus.op_drdy = 1'b0;
    pv_par = 0; pv_parr = 0; pv_lnp = 0; pv_op = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.par_drdy = 1'b0; bus.parr_srdy = 1'b0;
        bus.lnp_drdy = 1'b0; bus.op_drdy = 1'b0;
        pv_par = 0; pv_parr = 0; pv_lnp = 0; pv_op = 0;
      end else begin
        if (pv_par)  check("par_srdy_held",  32'(bus.par_srdy),  32'd1);
        if (pv_parr) check("parr_drdy_held", 32'(bus.parr_drdy), 32'd1);
        if (pv_lnp)  check("lnp_srdy_held",  32'(bus.lnp_srdy),  32'd1);
        if (pv_op)   check("op_srdy_held",   32'(bus.op_srdy),   32'd1);

        if (bus.par_srdy && hold_par > 0) begin bus.par_drdy = 1'b0; hold_par--; end
        else bus.par_drdy = !(rnd_stall && $urandom_range(3) == 0);

        if (bus.parr_drdy && hold_parr > 0) begin bus.parr_srdy = 1'b0; hold_parr--; end
        else bus.parr_srdy = (fl_q.size() > 0) && !(rnd_stall && $urandom_range(3) == 0);
        if (bus.parr_srdy) bus.parr_page = fl_q[0];
        else bus.parr_page = LPSZ'($urandom);
        if (bus.parr_srdy && bus.parr_drdy) void'(fl_q.pop_front());

        if (bus.lnp_srdy && hold_lnp > 0) begin bus.lnp_drdy = 1'b0; hold_lnp--; end
        else bus.lnp_drdy = !(rnd_stall && $urandom_range(3) == 0);
        if (bus.lnp_srdy) begin
          if (exp_lnp.size() == 0) check("lnp_spurious", 32'(bus.lnp_srdy), 32'd0);
          else begin
            check("lnp_pnp", 32'(bus.lnp_pnp), 32'(exp_lnp[0]));
            if (bus.lnp_drdy) void'(exp_lnp.pop_front());
          end
        end

        if (bus.op_srdy && hold_op > 0) begin bus.op_drdy = 1'b0; hold_op--; end
        else bus.op_drdy = !(rnd_stall && $urandom_range(3) == 0);
        if (bus.op_srdy) begin
          if (exp_op.size() == 0) check("op_spurious", 32'(bus.op_srdy), 32'd0);
          else begin
            check("op_page", 32'(bus.op_page), 32'(exp_op[0]));
            if (bus.op_drdy) begin
              void'(exp_op.pop_front());
              op_done_cyc = cyc + 1;
            end
          end
        end

        pv_par  = bus.par_srdy  && !bus.par_drdy;
        pv_parr = bus.parr_drdy && !bus.parr_srdy;
        pv_lnp  = bus.lnp_srdy  && !bus.lnp_drdy;
        pv_op   = bus.op_srdy   && !bus.op_drdy;
        if (bus.ip_drdy) ip_acks++;
      end
    end
  end

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ip_drdy && n < 1000);
    if (!bus.ip_drdy) check("ip_ack_timeout", 32'(bus.ip_drdy), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // A packet of pages p0..pn-1 links each page to its successor, the last to the stop page.
  task automatic send_packet(input int n);
    logic [LPSZ-1:0] pages[$];
    for (int i = 0; i < n; i++) begin
      if (pg_q.size() > 0) pages.push_back(pg_q.pop_front());
      else pages.push_back(LPSZ'($urandom));
    end
    exp_op.push_back(pages[0]);
    for (int i = 0; i < n; i++) begin
      fl_q.push_back(pages[i]);
      if (i == n - 1) exp_lnp.push_back({pages[i], STOP});
      else exp_lnp.push_back({pages[i], LPDSZ'(pages[i+1])});
    end
    exp_pkt  = exp_pkt + CNTW'(1);
    exp_page = exp_page + CNTW'(n);
    for (int i = 0; i < n; i++) begin
      bus.ip_srdy = 1'b1;
      bus.ip_eop  = (i == n - 1);
      wait_ack();
    end
    bus.ip_srdy = 1'b0;
    bus.ip_eop  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_op.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_op.size()), 32'd0);
    @(posedge clk);
    #1;
    check("lnp_left", 32'(exp_lnp.size()), 32'd0);
    check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
    check("page_count", 32'(page_count), 32'(exp_page));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ip_drdy"},   32'(bus.ip_drdy),   32'd0);
    check({tag, "_par_srdy"},  32'(bus.par_srdy),  32'd0);
    check({tag, "_parr_drdy"}, 32'(bus.parr_drdy), 32'd0);
    check({tag, "_lnp_srdy"},  32'(bus.lnp_srdy),  32'd0);
    check({tag, "_lnp_pnp"},   32'(bus.lnp_pnp),   32'd0);
    check({tag, "_op_srdy"},   32'(bus.op_srdy),   32'd0);
    check({tag, "_op_page"},   32'(bus.op_page),   32'd0);
    check({tag, "_pkt_cnt"},   32'(pkt_count),     32'd0);
    check({tag, "_page_cnt"},  32'(page_count),    32'd0);
  endtask

  task automatic clear_model();
    fl_q.delete(); exp_lnp.delete(); exp_op.delete(); pg_q.delete();
    exp_pkt = '0; exp_page = '0;
    hold_par = 0; hold_parr = 0; hold_lnp = 0; hold_op = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, a0, n;
    bus.ip_srdy = 1'b0;
    bus.ip_eop  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Single-page packet from page 5.
    pg_q = '{8'd5};
    a0 = ip_acks; t0 = cyc;
    send_packet(1);
    drain();
    check("single_latency", 32'(op_done_cyc - t0), 32'd6);
    check("single_acks", 32'(ip_acks - a0), 32'd1);

    // Three-page packet from pages 7, 3, 9.
    pg_q = '{8'd7, 8'd3, 8'd9};
    a0 = ip_acks; t0 = cyc;
    send_packet(3);
    drain();
    check("three_latency", 32'(op_done_cyc - t0), 32'd16);
    check("three_acks", 32'(ip_acks - a0), 32'd3);

    // Ten-cycle back-pressure on each channel in turn.
    for (int ch = 0; ch < 4; ch++) begin
      case (ch)
        0: hold_par  = 10;
        1: hold_parr = 10;
        2: hold_lnp  = 10;
        default: hold_op = 10;
      endcase
      t0 = cyc;
      send_packet(3);
      drain();
      check("stall_latency", 32'(op_done_cyc - t0), 32'd26);
      check("stall_used", 32'(hold_par + hold_parr + hold_lnp + hold_op), 32'd0);
    end

    // Back-to-back: one-page then two-page packet, no idle between tokens.
    t0 = cyc;
    send_packet(1);
    send_packet(2);
    drain();
    check("b2b_latency", 32'(op_done_cyc - t0), 32'd17);

    // Reset while the second page's link write is stalled.
    fl_q.push_back(8'd11); fl_q.push_back(8'd12);
    exp_lnp.push_back({8'd11, 9'd12});
    hold_lnp = 20;
    bus.ip_srdy = 1'b1; bus.ip_eop = 1'b0;
    wait_ack();
    bus.ip_eop = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.lnp_srdy && n < 100);
    check("link_reached", 32'(bus.lnp_srdy), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_zero("midreset");
    bus.ip_srdy = 1'b0; bus.ip_eop = 1'b0;
    clear_model();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    pg_q = '{8'd42};
    t0 = cyc;
    send_packet(1);
    drain();
    check("post_reset_latency", 32'(op_done_cyc - t0), 32'd6);

    // Random packets of 1..4 pages under random stalls on every channel.
    rnd_stall = 1'b1;
    for (int k = 0; k < 20; k++) send_packet(int'($urandom_range(4, 1)));
    drain();
    rnd_stall = 1'b0;

    // Counter wrap: 17 single-page packets after reset on a 4-bit counter.
    @(negedge clk) reset_n = 1'b0;
    clear_model();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 17; k++) send_packet(1);
    drain();
    check("wrap_pkt", 32'(pkt_count), 32'd1);
    check("wrap_page", 32'(page_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
